// File: rtl/scpu_pkg.sv
// scpu_pkg: shared opcode, state, ACC-source and ALU-op encodings for the SCPU control path
package scpu_pkg;
  localparam int OPC_W = 4;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;
  localparam logic [OPC_W-1:0] OPC_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OPC_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OPC_STA = 4'h2;
  localparam logic [OPC_W-1:0] OPC_ADD = 4'h3;
  localparam logic [OPC_W-1:0] OPC_SUB = 4'h4;
  localparam logic [OPC_W-1:0] OPC_AND = 4'h5;
  localparam logic [OPC_W-1:0] OPC_OR  = 4'h6;
  localparam logic [OPC_W-1:0] OPC_JMP = 4'h7;
  localparam logic [OPC_W-1:0] OPC_JZ  = 4'h8;
  localparam logic [OPC_W-1:0] OPC_IN  = 4'h9;
  localparam logic [OPC_W-1:0] OPC_OUT = 4'hA;
  localparam logic [OPC_W-1:0] OPC_HLT = 4'hF;
  localparam logic [1:0] ACC_SRC_ALU = 2'd0;
  localparam logic [1:0] ACC_SRC_MEM = 2'd1;
  localparam logic [1:0] ACC_SRC_IN  = 2'd2;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;
  function automatic logic is_mem(input logic [OPC_W-1:0] o);
    return o >= OPC_LDA && o <= OPC_OR;
  endfunction
  function automatic logic is_illegal(input logic [OPC_W-1:0] o);
    return o > OPC_OUT && o < OPC_HLT;
  endfunction
endpackage

// File: rtl/scpu_wait_timer.sv
// scpu_wait_timer: stall-cycle counter with clear/enable and a timeout compare against MAX_WAIT
module scpu_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  assign timeout = cnt == 8'(MAX_WAIT);
endmodule

// File: rtl/scpu_ctrl_seq.sv
// scpu_ctrl_seq: multi-cycle FETCH/DECODE/EXEC sequencer with memory wait stalls and bus-timeout watchdog
module scpu_ctrl_seq
  import scpu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       mem_ready,
  input  logic       acc_zero,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       acc_load,
  output logic [1:0] acc_src,
  output logic [1:0] alu_op,
  output logic       out_load,
  output logic       halted,
  output logic       bus_err,
  output logic       illegal,
  output logic [2:0] state_o
);
  state_t state, nxt;
  logic [OPC_W-1:0] opc;
  logic stall, timeout, err_set, mem_op;
  logic unused_operand;
  assign unused_operand = ^instr[3:0];
  assign mem_op = is_mem(opc);
  assign stall = !mem_ready && (state == S_FETCH || (state == S_EXEC && mem_op));
  assign state_o = state;
  scpu_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk), .rst(rst), .clr(nxt != state), .en(stall), .timeout(timeout)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= S_IDLE;
      opc     <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_FETCH && mem_ready) opc <= instr[7:4];
      if (err_set) bus_err <= 1'b1;
    end
  always_comb begin
    nxt      = state;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    acc_load = 1'b0;
    acc_src  = ACC_SRC_ALU;
    alu_op   = ALU_ADD;
    out_load = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    err_set  = 1'b0;
    case (state)
      S_IDLE: nxt = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_rd  = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
        nxt     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        illegal = is_illegal(opc);
        nxt     = (illegal || opc == OPC_NOP) ? S_FETCH : S_EXEC;
      end
      S_EXEC:
        if (mem_op) begin
          addr_sel = 1'b1;
          mem_rd   = opc != OPC_STA;
          mem_wr   = opc == OPC_STA;
          acc_load = mem_ready && opc != OPC_STA;
          acc_src  = (mem_ready && opc == OPC_LDA) ? ACC_SRC_MEM : ACC_SRC_ALU;
          alu_op   = (mem_ready && opc >= OPC_ADD) ? 2'(opc - OPC_ADD) : ALU_ADD;
          nxt      = mem_ready ? S_FETCH : S_EXEC;
        end else begin
          pc_load  = opc == OPC_JMP || (opc == OPC_JZ && acc_zero);
          acc_load = opc == OPC_IN;
          acc_src  = opc == OPC_IN ? ACC_SRC_IN : ACC_SRC_ALU;
          out_load = opc == OPC_OUT;
          nxt      = opc == OPC_HLT ? S_HALT : S_FETCH;
        end
      S_HALT: halted = 1'b1;
      default: nxt = S_IDLE;
    endcase
    // a stall that reaches the wait limit aborts to HALT; a same-cycle mem_ready never counts as a stall
    if (stall && timeout) begin
      nxt     = S_HALT;
      err_set = 1'b1;
    end
  end
endmodule

// File: tb/tb_scpu_ctrl_seq.sv
// tb_scpu_ctrl_seq: directed scenarios plus randomized programs checked against a behavioural model
module tb_scpu_ctrl_seq;
  localparam int MAX_WAIT = 15;
  logic clk = 1'b0;
  logic rst, run, mem_ready, acc_zero;
  logic [7:0] instr;
  logic ir_load, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_load, out_load, halted, bus_err, illegal;
  logic [1:0] acc_src, alu_op;
  logic [2:0] state_o;
  logic [17:0] obs;
  int checks = 0;
  int errors = 0;
  int m_ph, m_wait;
  logic [3:0] m_opc;
  bit m_err;
  scpu_ctrl_seq #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .mem_ready(mem_ready), .acc_zero(acc_zero),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .addr_sel(addr_sel), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .acc_load(acc_load), .acc_src(acc_src), .alu_op(alu_op), .out_load(out_load),
    .halted(halted), .bus_err(bus_err), .illegal(illegal), .state_o(state_o)
  );
  always #5 clk = ~clk;
  assign obs = {ir_load, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_load, acc_src, alu_op,
                out_load, halted, bus_err, illegal, state_o};
  task automatic drive(input logic r, input logic [7:0] ins, input logic rdy, input logic az);
    @(negedge clk);
    run = r; instr = ins; mem_ready = rdy; acc_zero = az;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; run = 1'b0; mem_ready = 1'b0; acc_zero = 1'b0; instr = 8'h00;
    @(negedge clk);
    rst = 1'b1;
  endtask
  function automatic logic [17:0] model_out(input logic rdy, input logic az);
    logic il = 0, pi = 0, pl = 0, asel = 0, rd = 0, wr = 0, al = 0, ol = 0, hl = 0, ill = 0;
    logic [1:0] src = 0, aop = 0;
    bit memop = m_opc >= 1 && m_opc <= 6;
    case (m_ph)
      1: begin rd = 1; il = rdy; pi = rdy; end
      2: ill = m_opc >= 4'hB && m_opc <= 4'hE;
      3: if (memop) begin
        asel = 1;
        if (m_opc == 2) wr = 1; else rd = 1;
        if (rdy && m_opc != 2) begin
          al = 1;
          src = m_opc == 1 ? 2'd1 : 2'd0;
          aop = m_opc == 1 ? 2'd0 : 2'(m_opc - 3);
        end
      end else begin
        pl = m_opc == 7 || (m_opc == 8 && az);
        al = m_opc == 9;
        src = m_opc == 9 ? 2'd2 : 2'd0;
        ol = m_opc == 10;
      end
      4: hl = 1;
      default: ;
    endcase
    return {il, pi, pl, asel, rd, wr, al, src, aop, ol, hl, logic'(m_err), ill, 3'(m_ph)};
  endfunction
  task automatic model_step(input logic r, input logic rdy, input logic [7:0] ins);
    bit memop = m_opc >= 1 && m_opc <= 6;
    bit stall = 0;
    int nph = m_ph;
    case (m_ph)
      0: if (r) nph = 1;
      1: if (rdy) begin nph = 2; m_opc = ins[7:4]; end else stall = 1;
      2: nph = (m_opc == 0 || (m_opc >= 11 && m_opc <= 14)) ? 1 : 3;
      3: if (!memop) nph = m_opc == 15 ? 4 : 1; else if (rdy) nph = 1; else stall = 1;
      default: ;
    endcase
    if (stall && m_wait == MAX_WAIT) begin m_err = 1; nph = 4; end
    m_wait = nph != m_ph ? 0 : stall ? m_wait + 1 : m_wait;
    m_ph = nph;
  endtask
  task automatic test_reset();
    rst = 1'b0; run = 1'b0; mem_ready = 1'b0; acc_zero = 1'b0; instr = 8'h00;
    @(negedge clk);
    checks++; if (obs !== 18'd0) begin errors++; $display("FAIL reset_init: outputs=%h expected 0", obs); end
    rst = 1'b1;
    drive(1, 8'h00, 0, 0);
    drive(1, 8'h00, 0, 0);
    checks++; if (state_o !== 3'd1 || mem_rd !== 1'b1) begin errors++; $display("FAIL reset_fetch: state=%0d mem_rd=%b expected 1/1", state_o, mem_rd); end
    rst = 1'b0; #1;
    checks++; if (obs !== 18'd0) begin errors++; $display("FAIL reset_async: outputs=%h expected 0", obs); end
    drive(1, 8'h00, 0, 0);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_hold: state=%0d expected 0", state_o); end
    rst = 1'b1;
    drive(1, 8'h00, 0, 0);
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL reset_restart: state=%0d expected 1", state_o); end
  endtask
  task automatic test_program();
    logic [7:0] prog [3] = '{8'h91, 8'hA0, 8'hF0};
    do_reset();
    drive(1, 8'h00, 1, 0);
    for (int c = 1; c <= 12; c++) begin
      drive(1, (c - 1) % 3 == 0 && c < 10 ? prog[(c - 1) / 3] : 8'h00, 1, 0);
      if (c == 3) begin
        checks++; if (acc_load !== 1'b1 || acc_src !== 2'd2) begin errors++; $display("FAIL in_exec: acc_load=%b acc_src=%0d expected 1/2", acc_load, acc_src); end
      end
      if (c == 6) begin
        checks++; if (out_load !== 1'b1 || acc_load !== 1'b0) begin errors++; $display("FAIL out_exec: out_load=%b acc_load=%b expected 1/0", out_load, acc_load); end
      end
      if (c == 9) begin
        checks++; if (state_o !== 3'd3 || halted !== 1'b0) begin errors++; $display("FAIL hlt_exec: state=%0d halted=%b expected 3/0", state_o, halted); end
      end
      if (c >= 10) begin
        checks++; if (halted !== 1'b1 || state_o !== 3'd4 || mem_rd !== 1'b0) begin errors++; $display("FAIL halt_hold c%0d: halted=%b state=%0d mem_rd=%b expected 1/4/0", c, halted, state_o, mem_rd); end
      end
    end
  endtask
  task automatic test_alu_stall();
    do_reset();
    drive(1, 8'h00, 1, 0);
    drive(1, 8'h35, 1, 0);
    drive(1, 8'h00, 1, 0);
    for (int c = 0; c < 3; c++) begin
      drive(0, 8'h00, 0, 0);
      checks++; if (mem_rd !== 1'b1 || addr_sel !== 1'b1 || acc_load !== 1'b0) begin errors++; $display("FAIL add_stall%0d: mem_rd=%b addr_sel=%b acc_load=%b expected 1/1/0", c, mem_rd, addr_sel, acc_load); end
    end
    drive(0, 8'h00, 1, 0);
    checks++; if (mem_rd !== 1'b1 || addr_sel !== 1'b1 || acc_load !== 1'b1 || alu_op !== 2'd0 || acc_src !== 2'd0) begin errors++; $display("FAIL add_ready: rd=%b sel=%b ld=%b op=%0d src=%0d expected 1/1/1/0/0", mem_rd, addr_sel, acc_load, alu_op, acc_src); end
    drive(0, 8'h00, 0, 0);
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL add_next: state=%0d expected 1", state_o); end
  endtask
  task automatic test_jz_back_to_back();
    logic az_v [2] = '{1'b1, 1'b0};
    do_reset();
    drive(1, 8'h00, 1, 0);
    for (int k = 0; k < 2; k++) begin
      drive(1, 8'h8C, 1, 0);
      drive(1, 8'h00, 1, ~az_v[k]);
      drive(1, 8'h00, 1, az_v[k]);
      checks++; if (pc_load !== az_v[k] || state_o !== 3'd3) begin errors++; $display("FAIL jz_az%0d: pc_load=%b state=%0d expected %b/3", az_v[k], pc_load, state_o, az_v[k]); end
    end
  endtask
  task automatic test_illegal();
    do_reset();
    drive(1, 8'h00, 1, 0);
    drive(1, 8'hC0, 1, 0);
    drive(1, 8'h00, 1, 0);
    checks++; if (illegal !== 1'b1 || acc_load !== 1'b0 || state_o !== 3'd2) begin errors++; $display("FAIL illegal_decode: illegal=%b acc_load=%b state=%0d expected 1/0/2", illegal, acc_load, state_o); end
    drive(1, 8'h00, 0, 0);
    checks++; if (illegal !== 1'b0 || state_o !== 3'd1) begin errors++; $display("FAIL illegal_next: illegal=%b state=%0d expected 0/1", illegal, state_o); end
  endtask
  task automatic test_timeout();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      drive(1, 8'h00, 0, 0);
      for (int c = 1; c <= 15; c++) drive(1, 8'h00, 0, 0);
      drive(1, 8'h90, k == 1, 0);
      checks++; if (bus_err !== 1'b0 || ir_load !== logic'(k == 1)) begin errors++; $display("FAIL wd_edge%0d: bus_err=%b ir_load=%b expected 0/%0d", k, bus_err, ir_load, k); end
      drive(1, 8'h00, 0, 0);
      if (k == 0) begin
        checks++; if (bus_err !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL wd_timeout: bus_err=%b halted=%b expected 1/1", bus_err, halted); end
      end else begin
        checks++; if (bus_err !== 1'b0 || state_o !== 3'd2) begin errors++; $display("FAIL wd_rescue: bus_err=%b state=%0d expected 0/2", bus_err, state_o); end
      end
    end
  endtask
  task automatic test_random();
    logic [17:0] exp;
    logic [3:0] op;
    int stall_left = 0;
    int halt_cnt = 0;
    do_reset();
    m_ph = 0; m_wait = 0; m_opc = 0; m_err = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0 || halt_cnt > 4) begin
        rst = 1'b0; #1;
        m_ph = 0; m_wait = 0; m_opc = 0; m_err = 0; halt_cnt = 0;
        exp = model_out(mem_ready, acc_zero);
        checks++; if (obs !== exp) begin errors++; $display("FAIL rand_reset i%0d: outputs=%h expected %h", i, obs, exp); end
        continue;
      end
      rst = 1'b1;
      run = $urandom_range(0, 7) != 0;
      if (stall_left > 0) begin
        mem_ready = 1'b0; stall_left--;
      end else begin
        if ($urandom_range(0, 59) == 0) stall_left = $urandom_range(12, 18);
        mem_ready = $urandom_range(0, 3) != 0;
      end
      acc_zero = 1'($urandom);
      op = $urandom_range(0, 39) == 0 ? 4'hF : 4'($urandom_range(0, 14));
      instr = {op, 4'($urandom)};
      #1;
      exp = model_out(mem_ready, acc_zero);
      checks++; if (obs !== exp) begin errors++; $display("FAIL rand i%0d: outputs=%h expected %h", i, obs, exp); end
      model_step(run, mem_ready, instr);
      halt_cnt = m_ph == 4 ? halt_cnt + 1 : 0;
    end
  endtask
  initial begin
    test_reset();
    test_program();
    test_alu_stall();
    test_jz_back_to_back();
    test_illegal();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
